// File: rtl/mc_mv_pkg.sv
// Shared constants and FSM encoding for the MC motion-vector RAM controller.
package mc_mv_pkg;

  localparam int MC_MV_WORD_W = 20;
  localparam int MC_MV_ADDR_W = 8;

  // Packed MV word layout: {mv_x[9:0], mv_y[9:0]}
  localparam int MC_MV_COMP_W = 10;
  localparam int MC_MV_Y_LSB  = 0;
  localparam int MC_MV_X_LSB  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } mc_mv_state_t;

endpackage

// File: rtl/mc_mv_arb.sv
// Read-priority arbiter with write anti-starvation: after RD_BURST_MAX reads
// granted while a write waits, the write is forced through.
module mc_mv_arb #(
  parameter int RD_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic rd_val,
  input  logic wr_val,
  output logic rd_rdy,
  output logic wr_rdy,
  output logic rd_gnt,
  output logic wr_gnt
);

  localparam int CNT_W = $clog2(RD_BURST_MAX + 1);

  logic [CNT_W-1:0] burst_cnt;
  logic             starve_full;

  assign starve_full = (burst_cnt == CNT_W'(RD_BURST_MAX));
  assign rd_rdy      = idle & ~(wr_val & starve_full);
  assign wr_rdy      = idle & (~rd_val | starve_full);
  assign rd_gnt      = rd_val & rd_rdy;
  assign wr_gnt      = wr_val & wr_rdy;

  // Counts reads that overtook a waiting write; saturates at RD_BURST_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (!wr_val || wr_gnt) begin
      burst_cnt <= '0;
    end else if (rd_gnt && !starve_full) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_mv_ram_ctrl.sv
// Access controller for the 20x256 single-port MV SRAM. Optional zero-fill
// sweep between LCUs is built when MC_MV_RAM_CLR_EN is defined.
module mc_mv_ram_ctrl
  import mc_mv_pkg::*;
#(
  parameter int WORD_W       = MC_MV_WORD_W,
  parameter int ADDR_W       = MC_MV_ADDR_W,
  parameter int RD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_val_i,
  output logic              wr_rdy_o,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [WORD_W-1:0] wr_dat_i,
  input  logic              rd_val_i,
  output logic              rd_rdy_o,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [WORD_W-1:0] rd_dat_o,
  output logic              rd_dat_val_o,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              ram_cen_o,
  output logic              ram_oen_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [WORD_W-1:0] ram_dat_o,
  input  logic [WORD_W-1:0] ram_dat_i
);

  logic              idle;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              rd_dat_val_reg;
  logic [ADDR_W-1:0] sweep_addr;

  mc_mv_arb #(.RD_BURST_MAX(RD_BURST_MAX)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .idle   (idle),
    .rd_val (rd_val_i),
    .wr_val (wr_val_i),
    .rd_rdy (rd_rdy_o),
    .wr_rdy (wr_rdy_o),
    .rd_gnt (rd_gnt),
    .wr_gnt (wr_gnt)
  );

`ifdef MC_MV_RAM_CLR_EN
  mc_mv_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic              clr_done_reg;
  logic              clr_last;

  assign clr_last = (clr_addr_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      clr_addr_reg <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_done_reg <= (state_reg == ST_CLR) && clr_last;
      clr_addr_reg <= (state_reg == ST_CLR) ? clr_addr_reg + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (clr_i)    state_next = ST_CLR;
      ST_CLR:  if (clr_last) state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  assign idle       = (state_reg == ST_IDLE);
  assign busy_o     = (state_reg == ST_CLR);
  assign clr_done_o = clr_done_reg;
  assign sweep_addr = clr_addr_reg;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign idle       = 1'b1;
  assign busy_o     = 1'b0;
  assign clr_done_o = 1'b0;
  assign sweep_addr = '0;
`endif

  // The sweep owns the port outright; otherwise at most one grant is live.
  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = rd_idx_i;
    ram_dat_o  = wr_dat_i;
    if (busy_o) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = sweep_addr;
      ram_dat_o  = '0;
    end else if (rd_gnt) begin
      ram_cen_o  = 1'b0;
    end else if (wr_gnt) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = wr_idx_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dat_val_reg <= 1'b0;
    else        rd_dat_val_reg <= rd_gnt;
  end

  assign ram_oen_o    = 1'b0;
  assign rd_dat_o     = ram_dat_i;
  assign rd_dat_val_o = rd_dat_val_reg;

endmodule

// File: tb/tb_mc_mv_ram_ctrl.sv
// Self-checking bench for mc_mv_ram_ctrl with an SRAM model and a reference
// model of the arbitration/clear rules; define MC_MV_RAM_CLR_EN for sweep tests.
module tb_mc_mv_ram_ctrl;

  localparam int RD_BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_val = 1'b0, rd_val = 1'b0, clr_i = 1'b0;
  logic [7:0]  wr_idx = '0, rd_idx = '0;
  logic [19:0] wr_dat = '0;
  logic        wr_rdy, rd_rdy, rd_dat_val, busy, clr_done;
  logic        ram_cen, ram_oen, ram_wen;
  logic [7:0]  ram_addr;
  logic [19:0] rd_dat, ram_dat_o, ram_q;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mc_mv_ram_ctrl #(.WORD_W(20), .ADDR_W(8), .RD_BURST_MAX(RD_BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_val_i(wr_val), .wr_rdy_o(wr_rdy), .wr_idx_i(wr_idx), .wr_dat_i(wr_dat),
    .rd_val_i(rd_val), .rd_rdy_o(rd_rdy), .rd_idx_i(rd_idx),
    .rd_dat_o(rd_dat), .rd_dat_val_o(rd_dat_val),
    .clr_i(clr_i), .busy_o(busy), .clr_done_o(clr_done),
    .ram_cen_o(ram_cen), .ram_oen_o(ram_oen), .ram_wen_o(ram_wen),
    .ram_addr_o(ram_addr), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_q)
  );

  // Single-port SRAM with registered read data.
  logic [19:0] sram [256];
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) sram[ram_addr] <= ram_dat_o;
      else          ram_q <= sram[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [19:0] ref_mem [256];
  bit          known [256];
  int          streak = 0;
  bit          m_clr = 0, m_done = 0, m_rdv = 0, m_rknown = 0;
  logic [7:0]  m_clr_addr = '0;
  logic [19:0] m_rdata = '0;

  logic        e_rd_rdy, e_wr_rdy, e_rg, e_wg, e_cen, e_wen;
  logic [7:0]  e_addr;
  logic [19:0] e_dat;

  always_comb begin
    e_rd_rdy = !m_clr && !(wr_val && (streak >= RD_BURST_MAX));
    e_wr_rdy = !m_clr && (!rd_val || (streak >= RD_BURST_MAX));
    e_rg     = rd_val && e_rd_rdy;
    e_wg     = wr_val && e_wr_rdy;
    e_cen    = !(m_clr || e_rg || e_wg);
    e_wen    = !(m_clr || e_wg);
    e_addr   = m_clr ? m_clr_addr : (e_rg ? rd_idx : wr_idx);
    e_dat    = m_clr ? 20'h0 : wr_dat;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_clr) for (int i = 0; i < 256; i++) known[i] <= 1'b0;
      streak     <= 0;
      m_clr      <= 1'b0;
      m_done     <= 1'b0;
      m_rdv      <= 1'b0;
      m_clr_addr <= '0;
    end else begin
      m_rdv <= e_rg;
      if (e_rg) begin
        m_rdata  <= ref_mem[rd_idx];
        m_rknown <= known[rd_idx];
      end
      if (e_wg) begin
        ref_mem[wr_idx] <= wr_dat;
        known[wr_idx]   <= 1'b1;
      end
      if (!wr_val || e_wg) streak <= 0;
      else if (e_rg && streak < RD_BURST_MAX) streak <= streak + 1;
      m_done <= 1'b0;
`ifdef MC_MV_RAM_CLR_EN
      if (m_clr) begin
        ref_mem[m_clr_addr] <= 20'h0;
        known[m_clr_addr]   <= 1'b1;
        m_clr_addr          <= m_clr_addr + 8'd1;
        if (m_clr_addr == 8'hFF) begin
          m_clr  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (clr_i) begin
        m_clr      <= 1'b1;
        m_clr_addr <= '0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ctrl", 32'({rd_rdy, wr_rdy, ram_cen, ram_wen, ram_oen, busy, clr_done, rd_dat_val}),
            32'({e_rd_rdy, e_wr_rdy, e_cen, e_wen, 1'b0, m_clr, m_done, m_rdv}));
      if (!e_cen) check("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (!e_wen) check("ram_wdat", 32'(ram_dat_o), 32'(e_dat));
      if (m_rdv && m_rknown) check("rd_dat", 32'(rd_dat), 32'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [7:0] idx, input logic [19:0] dat);
    bit ok;
    ok = 1'b0;
    wr_val = 1'b1; wr_idx = idx; wr_dat = dat;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = wr_rdy;
    end
    if (!ok) check("wr_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    wr_val = 1'b0;
    $display("write idx=%0d dat=0x%05h", idx, dat);
  endtask

  task automatic do_read(input logic [7:0] idx, input logic [19:0] exp);
    bit ok;
    ok = 1'b0;
    rd_val = 1'b1; rd_idx = idx;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = rd_rdy;
    end
    if (!ok) check("rd_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    rd_val = 1'b0;
    @(negedge clk);
    check("rd_lat_val", 32'(rd_dat_val), 32'd1);
    check("rd_lit", 32'(rd_dat), 32'(exp));
    $display("read  idx=%0d dat=0x%05h", idx, rd_dat);
    @(posedge clk); #1;
  endtask

  initial begin
    int          wait_cnt, max_wait, busy_cnt, done_cnt;
    logic [14:0] pat;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", 32'({rd_dat_val, busy, clr_done, ram_cen, ram_wen, ram_oen}), 32'b000110);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then immediate read.
    do_write(8'd7, 20'h12345);
    do_read(8'd7, 20'h12345);

    // Same-address read and write in one cycle.
    do_write(8'd3, 20'h00001);
    rd_val = 1'b1; rd_idx = 8'd3;
    wr_val = 1'b1; wr_idx = 8'd3; wr_dat = 20'h0ABCD;
    @(negedge clk);
    check("same_addr_gnt", 32'({rd_rdy, wr_rdy}), 32'b10);
    @(posedge clk); #1;
    rd_val = 1'b0;
    @(negedge clk);
    check("same_addr_old", 32'(rd_dat), 32'h00001);
    check("same_addr_wr_next", 32'(wr_rdy), 32'd1);
    @(posedge clk); #1;
    wr_val = 1'b0;
    $display("same-addr read returned 0x%05h", rd_dat);
    do_read(8'd3, 20'h0ABCD);

    // Continuous read + write streams.
    rd_val = 1'b1; wr_val = 1'b1; wr_idx = 8'd20; wr_dat = 20'h55555;
    wait_cnt = 0; max_wait = 0; pat = '0;
    for (int k = 0; k < 15; k++) begin
      rd_idx = 8'(k);
      @(negedge clk);
      pat[k] = wr_rdy;
      wait_cnt++;
      if (wr_rdy) begin
        if (wait_cnt > max_wait) max_wait = wait_cnt;
        wait_cnt = 0;
      end
      @(posedge clk); #1;
    end
    rd_val = 1'b0; wr_val = 1'b0;
    $display("burst grant pattern (1=write) %b", pat);
    check("burst_pattern", 32'(pat), 32'(15'b100001000010000));
    check("max_wr_wait", 32'(max_wait), 32'd5);
    do_read(8'd20, 20'h55555);

`ifdef MC_MV_RAM_CLR_EN
    for (int i = 0; i < 256; i++) do_write(8'(i), 20'hFFFFF);
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 270; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && (rd_rdy || wr_rdy)) check("busy_rdy_low", 32'({rd_rdy, wr_rdy}), 32'd0);
      if (clr_done) done_cnt++;
    end
    @(posedge clk); #1;
    $display("sweep busy=%0d done_pulses=%0d", busy_cnt, done_cnt);
    check("sweep_busy_cycles", 32'(busy_cnt), 32'd256);
    check("sweep_done_pulses", 32'(done_cnt), 32'd1);
    do_read(8'd0, 20'h0);
    do_read(8'd128, 20'h0);
    do_read(8'd255, 20'h0);

    // Reset during the sweep.
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midsweep_reset", 32'({rd_dat_val, busy, clr_done, ram_cen, ram_wen, ram_oen}), 32'b000110);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({rd_rdy, busy}), 32'b10);
    @(posedge clk); #1;
    do_write(8'd0, 20'h2468A);
    do_read(8'd0, 20'h2468A);
`else
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("clr_ignored", 32'({busy, clr_done, ram_cen, rd_rdy}), 32'b0011);
    end
    @(posedge clk); #1;
    do_read(8'd7, 20'h12345);
    do_read(8'd3, 20'h0ABCD);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
